bp_be_csr_rmw_ctrl: RTL and testbench
=====================================

Name: bp_be_csr_rmw_ctrl

Overview:
Read-modify-write sequencer that sits directly upstream of a 64-bit enabled reset register holding one backend CSR (reset value 0x80000124). It accepts CSR RW/RS/RC/read requests and samples the register's current value. It computes the legal new value under a writable-bit mask and drives the register's enable/data pins for exactly one cycle. It returns the old value to the requester over a valid/ready handshake.

Parameters:
width_p, 64, CSR data width
wmask_p, 64'h00000000_FFFFFFFF, writable-bit mask; 1 = software-writable
reset_val_p, 64'h00000000_80000124, value the downstream register resets to (documentation/assertions only)

Ports:
clk_i  in  1  clock; all state on rising edge
reset_n_i  in  1  asynchronous, active-low reset
v_i  in  1  request valid
ready_o  out  1  request accepted when v_i & ready_o
op_i  in  2  00 read-only, 01 RW, 10 RS, 11 RC
operand_i  in  width_p  rs1/immediate operand
reg_q_i  in  width_p  current value from downstream register output
reg_en_o  out  1  write enable to downstream register
reg_d_o  out  width_p  write data to downstream register
v_o  out  1  response valid
ready_i  in  1  response consumed when v_o & ready_i
data_o  out  width_p  old CSR value (pre-write)
err_o  out  1  qualified by v_o; write touched a read-only bit, write suppressed

Behaviour:
- Reset (async, reset_n_i=0): state IDLE; ready_o=0 while reset asserted, 1 in IDLE after release; reg_en_o=0, reg_d_o=0, v_o=0, data_o=0, err_o=0. Reset asserted in any state aborts the operation immediately; no reg_en_o pulse follows.
- States: IDLE, WRITE, RESP. ready_o=1 only in IDLE. Throughput: one request per 3 cycles with a write, one per 2 cycles without a write, given ready_i=1.
- IDLE, on accept: capture old=reg_q_i into data_o.
  - Compute raw: RW=operand_i, RS=old|operand_i, RC=old&~operand_i.
  - Set wr = (op_i==RW) | ((op_i==RS|RC) & operand_i!=0). op 00 → wr=0.
  - Set illegal = wr & (((raw^old)&~wmask_p)!=0).
  - If wr & ~illegal: load reg_d_o=raw, err_o=0, go WRITE.
  - Else: err_o=illegal, go RESP.
- WRITE: reg_en_o=1 for exactly this one cycle, with reg_d_o stable; the register captures at this cycle's edge. Next: RESP. reg_en_o=0 in all other states.
- RESP: v_o=1; data_o and err_o held stable until ready_i=1. On v_o&ready_i: IDLE. A new request cannot be accepted in the handshake cycle.
- Latency from accept edge: write visible on reg_q_i after 2 edges; v_o asserted 2 cycles after accept (write) or 1 cycle after accept (no write).
- reg_d_o holds its last value when not writing. Downstream ignores it while reg_en_o=0.
- v_i while not ready_o: ignored; the requester holds it.
- Operand bits outside wmask_p:
  - RS/RC setting or clearing an already-equal bit is legal (no change).
  - Any change to a read-only bit → err_o=1, no write.

Test Plan:
- Reset release, reg_q_i=0x80000124, op=RS, operand=0x8 → reg_en_o pulse with reg_d_o=0x8000012C 1 cycle after accept; v_o next cycle with data_o=0x80000124, err_o=0.
- op=RC, operand=0x80000000 on 0x8000012C → reg_d_o=0x0000012C, data_o=0x8000012C.
- op=RW, operand=0x1_DEADBEEF on 0x0000012C → no reg_en_o, v_o 1 cycle after accept, err_o=1, data_o=0x0000012C. Then RW 0xDEADBEEF → reg_d_o=0xDEADBEEF, err_o=0.
- op=00 and op=RS with operand=0 → reg_en_o never asserted; v_o 1 cycle after accept; data_o=reg_q_i.
- Backpressure: ready_i=0 for 4 cycles in RESP → v_o, data_o, err_o stable, ready_o=0, second v_i not accepted until after handshake.
- reset_n_i pulsed low during WRITE → reg_en_o drops asynchronously; v_o=0 after release, state IDLE, ready_o=1.

Source files
------------

// File: rtl/bp_be_csr_rmw_ctrl.sv
// ----------------------------------------------------------------------------
// bp_be_csr_rmw_ctrl
//
// Purpose:
//   Read-modify-write sequencer in front of a single 64-bit enabled reset
//   register that holds one backend CSR. A request (read, RW, RS, RC) samples
//   the register's current value. The sequencer computes the new value and
//   checks it against the writable-bit mask. If the write is legal, it pulses
//   the register's enable for exactly one cycle. The old value, plus an error
//   flag, is then returned over a valid/ready handshake.
//
// Ports:
//   clk_i      in   1        clock, all state on rising edge
//   reset_n_i  in   1        asynchronous active-low reset
//   v_i        in   1        request valid
//   ready_o    out  1        request accepted on v_i & ready_o (IDLE only)
//   op_i       in   2        00 read, 01 RW, 10 RS, 11 RC
//   operand_i  in   width_p  rs1 / immediate operand
//   reg_q_i    in   width_p  current value of the downstream register
//   reg_en_o   out  1        one-cycle write enable to the downstream register
//   reg_d_o    out  width_p  write data; holds its last value when not writing
//   v_o        out  1        response valid
//   ready_i    in   1        response consumed on v_o & ready_i
//   data_o     out  width_p  old (pre-write) CSR value
//   err_o      out  1        write would change a read-only bit; write dropped
// ----------------------------------------------------------------------------

// Protocol checker for the sequencer. It has no outputs and is simulation-only
// in effect.
module bp_be_csr_rmw_ctrl_chk #(
  parameter int                 width_p     = 64,
  parameter logic [width_p-1:0] wmask_p     = 64'h00000000_FFFFFFFF,
  parameter logic [width_p-1:0] reset_val_p = 64'h00000000_80000124
) (
  input logic               clk_i,
  input logic               reset_n_i,
  input logic               ready_o,
  input logic               reg_en_o,
  input logic [width_p-1:0] reg_d_o,
  input logic               v_o,
  input logic               ready_i,
  input logic [width_p-1:0] data_o,
  input logic               err_o
);

  // The enable is a single-cycle pulse.
  a_en_pulse: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    reg_en_o |=> !reg_en_o);

  // Accepting, writing and responding are mutually exclusive phases.
  a_phase_excl: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (ready_o |-> (!v_o && !reg_en_o)) and (reg_en_o |-> !v_o));

  // Read-only bits can only ever be written back with their reset value.
  a_ro_bits: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    reg_en_o |-> (((reg_d_o ^ reset_val_p) & ~wmask_p) == {width_p{1'b0}}));

  // A stalled response holds its payload.
  a_resp_hold: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (v_o && !ready_i) |=> (v_o && $stable(data_o) && $stable(err_o)));

endmodule

module bp_be_csr_rmw_ctrl #(
  parameter int                 width_p     = 64,
  parameter logic [width_p-1:0] wmask_p     = 64'h00000000_FFFFFFFF,
  parameter logic [width_p-1:0] reset_val_p = 64'h00000000_80000124
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [1:0]         op_i,
  input  logic [width_p-1:0] operand_i,
  input  logic [width_p-1:0] reg_q_i,
  output logic               reg_en_o,
  output logic [width_p-1:0] reg_d_o,
  output logic               v_o,
  input  logic               ready_i,
  output logic [width_p-1:0] data_o,
  output logic               err_o
);

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e             state_q;
  logic               ready_q;
  logic               reg_en_q;
  logic [width_p-1:0] reg_d_q;
  logic               v_q;
  logic [width_p-1:0] data_q;
  logic               err_q;

  logic [width_p-1:0] raw_s;
  logic               wr_s;
  logic               illegal_s;

  // New-value computation and legality check on the live request.
  always_comb begin
    raw_s     = reg_q_i;
    wr_s      = 1'b0;
    illegal_s = 1'b0;
    case (op_i)
      OP_READ: begin
        raw_s = reg_q_i;
        wr_s  = 1'b0;
      end
      OP_RW: begin
        raw_s = operand_i;
        wr_s  = 1'b1;
      end
      OP_RS: begin
        raw_s = reg_q_i | operand_i;
        wr_s  = (operand_i != {width_p{1'b0}});
      end
      OP_RC: begin
        raw_s = reg_q_i & ~operand_i;
        wr_s  = (operand_i != {width_p{1'b0}});
      end
      default: begin
        raw_s = reg_q_i;
        wr_s  = 1'b0;
      end
    endcase
    // Only an actual change to a read-only bit is illegal. Setting or
    // clearing a read-only bit that already has that value is allowed.
    if (wr_s) begin
      illegal_s = (((raw_s ^ reg_q_i) & ~wmask_p) != {width_p{1'b0}});
    end else begin
      illegal_s = 1'b0;
    end
  end

  // Sequencer FSM. All outputs are registered, and reset aborts any pending
  // write immediately.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      reg_en_q <= 1'b0;
      reg_d_q  <= {width_p{1'b0}};
      v_q      <= 1'b0;
      data_q   <= {width_p{1'b0}};
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (v_i && ready_q) begin
            data_q  <= reg_q_i;
            ready_q <= 1'b0;
            if (wr_s && !illegal_s) begin
              reg_d_q  <= raw_s;
              err_q    <= 1'b0;
              reg_en_q <= 1'b1;
              state_q  <= WRITE;
            end else begin
              err_q   <= illegal_s;
              v_q     <= 1'b1;
              state_q <= RESP;
            end
          end else begin
            // Also raises ready on the first edge after reset release.
            ready_q <= 1'b1;
          end
        end
        WRITE: begin
          // The downstream register captures reg_d_q on this edge.
          reg_en_q <= 1'b0;
          v_q      <= 1'b1;
          state_q  <= RESP;
        end
        RESP: begin
          if (ready_i) begin
            // ready is raised for the following cycle. No accept is possible
            // in the handshake cycle itself.
            v_q     <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            v_q     <= 1'b1;
            state_q <= RESP;
          end
        end
        default: begin
          state_q  <= IDLE;
          ready_q  <= 1'b0;
          reg_en_q <= 1'b0;
          v_q      <= 1'b0;
          err_q    <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign reg_en_o = reg_en_q;
  assign reg_d_o  = reg_d_q;
  assign v_o      = v_q;
  assign data_o   = data_q;
  assign err_o    = err_q;

  bp_be_csr_rmw_ctrl_chk #(
    .width_p    (width_p),
    .wmask_p    (wmask_p),
    .reset_val_p(reset_val_p)
  ) u_chk (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .ready_o  (ready_o),
    .reg_en_o (reg_en_o),
    .reg_d_o  (reg_d_o),
    .v_o      (v_o),
    .ready_i  (ready_i),
    .data_o   (data_o),
    .err_o    (err_o)
  );

endmodule

// File: tb/tb_bp_be_csr_rmw_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bp_be_csr_rmw_ctrl
//
// Directed bench for the CSR read-modify-write sequencer. A small model of the
// downstream enabled reset register (reset value 0x80000124) closes the loop.
// Main traffic comes from a table of vectors with hand-computed results, which
// chain through the register value. Hand-written sequences cover reset,
// response backpressure and reset during the write cycle.
// Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_bp_be_csr_rmw_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        v_i;
  logic        ready_o;
  logic [1:0]  op_i;
  logic [63:0] operand_i;
  logic [63:0] reg_q_i;
  logic        reg_en_o;
  logic [63:0] reg_d_o;
  logic        v_o;
  logic        ready_i;
  logic [63:0] data_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  // Downstream register model.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) reg_q_i <= 64'h00000000_80000124;
    else if (reg_en_o) reg_q_i <= reg_d_o;
  end

  bp_be_csr_rmw_ctrl dut (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .v_i      (v_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .operand_i(operand_i),
    .reg_q_i  (reg_q_i),
    .reg_en_o (reg_en_o),
    .reg_d_o  (reg_d_o),
    .v_o      (v_o),
    .ready_i  (ready_i),
    .data_o   (data_o),
    .err_o    (err_o)
  );

  typedef struct {
    logic [1:0]  op;
    logic [63:0] operand;
    logic        wr;
    logic [63:0] d;
    logic [63:0] data;
    logic        err;
    logic [63:0] after;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One full transaction with ready_i=1. It starts and ends on a falling edge.
  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    chk({tag, ".ready"}, {63'd0, ready_o}, 64'd1);
    v_i = 1'b1; op_i = v.op; operand_i = v.operand; ready_i = 1'b1;
    @(negedge clk_i);
    v_i = 1'b0;
    if (v.wr) begin
      chk({tag, ".en"},    {63'd0, reg_en_o}, 64'd1);
      chk({tag, ".d"},     reg_d_o, v.d);
      chk({tag, ".v_early"}, {63'd0, v_o}, 64'd0);
      @(negedge clk_i);
    end
    chk({tag, ".en_off"}, {63'd0, reg_en_o}, 64'd0);
    chk({tag, ".v"},      {63'd0, v_o}, 64'd1);
    chk({tag, ".data"},   data_o, v.data);
    chk({tag, ".err"},    {63'd0, err_o}, {63'd0, v.err});
    @(negedge clk_i);
    chk({tag, ".v_done"}, {63'd0, v_o}, 64'd0);
    chk({tag, ".reg"},    reg_q_i, v.after);
  endtask

  initial begin
    vec_t fin;
    //               op     operand                 wr    d                       data                    err   after
    vecs[0]  = '{2'b10, 64'h00000000_00000008, 1'b1, 64'h00000000_8000012C, 64'h00000000_80000124, 1'b0, 64'h00000000_8000012C};
    vecs[1]  = '{2'b11, 64'h00000000_80000000, 1'b1, 64'h00000000_0000012C, 64'h00000000_8000012C, 1'b0, 64'h00000000_0000012C};
    vecs[2]  = '{2'b01, 64'h00000001_DEADBEEF, 1'b0, 64'h0,                 64'h00000000_0000012C, 1'b1, 64'h00000000_0000012C};
    vecs[3]  = '{2'b01, 64'h00000000_DEADBEEF, 1'b1, 64'h00000000_DEADBEEF, 64'h00000000_0000012C, 1'b0, 64'h00000000_DEADBEEF};
    vecs[4]  = '{2'b00, 64'h00000000_0000FFFF, 1'b0, 64'h0,                 64'h00000000_DEADBEEF, 1'b0, 64'h00000000_DEADBEEF};
    vecs[5]  = '{2'b10, 64'h00000000_00000000, 1'b0, 64'h0,                 64'h00000000_DEADBEEF, 1'b0, 64'h00000000_DEADBEEF};
    vecs[6]  = '{2'b10, 64'hFFFFFFFF_00000000, 1'b0, 64'h0,                 64'h00000000_DEADBEEF, 1'b1, 64'h00000000_DEADBEEF};
    vecs[7]  = '{2'b11, 64'hFFFFFFFF_00000000, 1'b1, 64'h00000000_DEADBEEF, 64'h00000000_DEADBEEF, 1'b0, 64'h00000000_DEADBEEF};
    vecs[8]  = '{2'b11, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 64'h00000000_00000000, 64'h00000000_DEADBEEF, 1'b0, 64'h00000000_00000000};
    vecs[9]  = '{2'b10, 64'h00000001_00000001, 1'b0, 64'h0,                 64'h00000000_00000000, 1'b1, 64'h00000000_00000000};
    vecs[10] = '{2'b01, 64'h00000000_00000000, 1'b1, 64'h00000000_00000000, 64'h00000000_00000000, 1'b0, 64'h00000000_00000000};
    vecs[11] = '{2'b01, 64'h00000000_80000124, 1'b1, 64'h00000000_80000124, 64'h00000000_00000000, 1'b0, 64'h00000000_80000124};

    reset_n_i = 1'b0; v_i = 1'b0; op_i = 2'b00; operand_i = 64'd0; ready_i = 1'b1;

    // Reset state.
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst.ready",  {63'd0, ready_o},  64'd0);
    chk("rst.en",     {63'd0, reg_en_o}, 64'd0);
    chk("rst.d",      reg_d_o,           64'd0);
    chk("rst.v",      {63'd0, v_o},      64'd0);
    chk("rst.data",   data_o,            64'd0);
    chk("rst.err",    {63'd0, err_o},    64'd0);
    reset_n_i = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Backpressure: illegal RW (bit 32) on 0x80000124, held for 4 stalled
    // cycles. v_i stays high so a second copy waits behind the handshake.
    v_i = 1'b1; op_i = 2'b01; operand_i = 64'h00000001_00000000; ready_i = 1'b0;
    @(negedge clk_i);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("bp%0d.v", c),     {63'd0, v_o},      64'd1);
      chk($sformatf("bp%0d.data", c),  data_o,            64'h00000000_80000124);
      chk($sformatf("bp%0d.err", c),   {63'd0, err_o},    64'd1);
      chk($sformatf("bp%0d.ready", c), {63'd0, ready_o},  64'd0);
      chk($sformatf("bp%0d.en", c),    {63'd0, reg_en_o}, 64'd0);
      @(negedge clk_i);
    end
    ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp.hs_v",     {63'd0, v_o},     64'd0);
    chk("bp.hs_ready", {63'd0, ready_o}, 64'd1);
    @(negedge clk_i);
    chk("bp.second_v",     {63'd0, v_o},     64'd1);
    chk("bp.second_ready", {63'd0, ready_o}, 64'd0);
    chk("bp.second_err",   {63'd0, err_o},   64'd1);
    v_i = 1'b0;
    @(negedge clk_i);
    chk("bp.done_v", {63'd0, v_o}, 64'd0);
    chk("bp.reg",    reg_q_i,      64'h00000000_80000124);

    // Reset asserted during the WRITE cycle aborts the write.
    v_i = 1'b1; op_i = 2'b10; operand_i = 64'h00000000_00000001;
    @(negedge clk_i);
    v_i = 1'b0;
    chk("rw.en_before", {63'd0, reg_en_o}, 64'd1);
    reset_n_i = 1'b0;
    #1;
    chk("rw.en_async", {63'd0, reg_en_o}, 64'd0);
    chk("rw.v_async",  {63'd0, v_o},      64'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    chk("rw.ready", {63'd0, ready_o},  64'd1);
    chk("rw.v",     {63'd0, v_o},      64'd0);
    chk("rw.en",    {63'd0, reg_en_o}, 64'd0);
    @(negedge clk_i);
    chk("rw.v_later",  {63'd0, v_o},      64'd0);
    chk("rw.en_later", {63'd0, reg_en_o}, 64'd0);
    chk("rw.reg",      reg_q_i,           64'h00000000_80000124);

    // Normal operation resumes after the aborted write.
    fin = '{2'b10, 64'h00000000_00000008, 1'b1, 64'h00000000_8000012C,
            64'h00000000_80000124, 1'b0, 64'h00000000_8000012C};
    run_vec(99, fin);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
